dac_sample_fifo: RTL and testbench

- Upstream feeder for the dacx311 serializer.
- Buffers 12-bit DAC samples and 2-bit power-down codes, pushed by a producer over a valid/ready handshake.
- Drives the serializer's data/pd inputs and holds them stable while a frame is being shifted.
- Advances to the next sample only when spi_master_ctrl signals frame completion (rising edge of its ready).

---
 rtl/dac_sample_fifo.sv | 99 +++++++++
 tb/tb_dac_sample_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_fifo.sv
// Sample FIFO that feeds the dacx311 serializer. A new sample is presented only on a
// rising edge of spi_ready (frame complete); otherwise data/pd are held.
module dac_sample_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [11:0]   in_data,
   input  logic [1:0]    in_pd,
   input  logic          spi_ready,
   output logic [11:0]   data,
   output logic [1:0]    pd,
   output logic [AW:0]   level,
   output logic          underrun,
   output logic [7:0]    underrun_cnt,
   input  logic          clear_cnt
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [13:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          spi_ready_q;
   logic [11:0]   data_q, data_d;
   logic [1:0]    pd_q, pd_d;
   logic          underrun_q, underrun_d;
   logic [7:0]    underrun_cnt_q, underrun_cnt_d;

   logic full, empty, push, pop, frame_edge;

   always_comb begin
      full       = (level_q == FULL_LVL);
      empty      = (level_q == '0);
      push       = in_valid & ~full;
      frame_edge = spi_ready & ~spi_ready_q;
      pop        = frame_edge & ~empty;

      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      level_d        = level_q;
      data_d         = data_q;
      pd_d           = pd_q;
      underrun_d     = frame_edge & empty;
      underrun_cnt_d = underrun_cnt_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         data_d   = mem_q[rd_ptr_q][11:0];
         pd_d     = mem_q[rd_ptr_q][13:12];
      end
      // An empty-FIFO push is never bypassed; it simply lands in storage.
      level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      if (clear_cnt)
         underrun_cnt_d = '0;
      else if (underrun_d && underrun_cnt_q != 8'hff)
         underrun_cnt_d = underrun_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_pd, in_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         spi_ready_q    <= 1'b0;
         data_q         <= '0;
         pd_q           <= '0;
         underrun_q     <= 1'b0;
         underrun_cnt_q <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         spi_ready_q    <= spi_ready;
         data_q         <= data_d;
         pd_q           <= pd_d;
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign in_ready     = ~full;
   assign data         = data_q;
   assign pd           = pd_q;
   assign level        = level_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed bench for dac_sample_fifo: spi_ready is driven directly to mimic frame boundaries.
module tb_dac_sample_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [11:0]   in_data;
   logic [1:0]    in_pd;
   logic          spi_ready;
   logic [11:0]   data;
   logic [1:0]    pd;
   logic [AW:0]   level;
   logic          underrun;
   logic [7:0]    underrun_cnt;
   logic          clear_cnt;

   int n_cmp = 0;
   int n_err = 0;

   dac_sample_fifo #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_pd        (in_pd),
      .spi_ready    (spi_ready),
      .data         (data),
      .pd           (pd),
      .level        (level),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .clear_cnt    (clear_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // 16-bit word the serializer shifts out for the presented sample
   function automatic logic [15:0] frame_word();
      return {pd, data, 2'b00};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [11:0] d, input logic [1:0] p);
      in_valid = 1'b1;
      in_data  = d;
      in_pd    = p;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic frame();
      spi_ready = 1'b0;
      repeat (2) tick();
      spi_ready = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_pd = '0;
      spi_ready = 1'b0; clear_cnt = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_data", data, 0);
      chk("rst_pd", pd, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_cnt", underrun_cnt, 0);

      push(12'hfff, 2'd0);
      chk("push1_level", level, 1);
      frame();
      chk("f1_data", data, 12'hfff);
      chk("f1_word", frame_word(), 16'h3ffc);
      chk("f1_level", level, 0);
      chk("f1_underrun", underrun, 0);

      push(12'h123, 2'd0);
      push(12'h456, 2'd0);
      push(12'h789, 2'd0);
      chk("burst_level", level, 3);
      frame();
      chk("f2_word", frame_word(), 16'h048c);
      chk("f2_level", level, 2);
      frame();
      chk("f3_word", frame_word(), 16'h1158);
      chk("f3_level", level, 1);
      frame();
      chk("f4_word", frame_word(), 16'h1e24);
      chk("f4_level", level, 0);

      spi_ready = 1'b0;
      tick();
      push(12'habc, 2'd1);
      tick();
      chk("mid_hold_word", frame_word(), 16'h1e24);
      chk("mid_level", level, 1);
      spi_ready = 1'b1;
      tick();
      chk("mid_new_data", data, 12'habc);
      chk("mid_new_pd", pd, 2'd1);
      chk("mid_new_word", frame_word(), 16'h6af0);

      frame();
      chk("ur1_pulse", underrun, 1);
      chk("ur1_data", data, 12'habc);
      chk("ur1_cnt", underrun_cnt, 1);
      tick();
      chk("ur1_pulse_end", underrun, 0);
      frame();
      chk("ur2_pulse", underrun, 1);
      chk("ur2_cnt", underrun_cnt, 2);
      chk("ur2_data", data, 12'habc);
      clear_cnt = 1'b1;
      tick();
      clear_cnt = 1'b0;
      chk("clear_cnt", underrun_cnt, 0);
      frame();
      chk("ur3_cnt", underrun_cnt, 1);

      spi_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) push(12'h100 + 12'(i), 2'd2);
      chk("full_level", level, 16);
      chk("full_in_ready", in_ready, 0);
      in_valid = 1'b1; in_data = 12'h555; in_pd = 2'd3;
      tick();
      chk("full_reject_level", level, 16);
      spi_ready = 1'b1;
      tick();
      chk("full_pop_level", level, 15);
      chk("full_pop_data", data, 12'h100);
      chk("full_pop_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("refill_level", level, 16);
      frame();
      chk("f_next_data", data, 12'h101);
      chk("f_next_level", level, 15);

      spi_ready = 1'b0;
      tick();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      chk("mrst_level", level, 0);
      chk("mrst_data", data, 0);
      chk("mrst_pd", pd, 0);
      chk("mrst_cnt", underrun_cnt, 0);
      chk("mrst_in_ready", in_ready, 1);

      spi_ready = 1'b1; in_valid = 1'b1; in_data = 12'h777; in_pd = 2'd0;
      tick();
      in_valid = 1'b0;
      chk("empty_pp_underrun", underrun, 1);
      chk("empty_pp_level", level, 1);
      chk("empty_pp_data", data, 0);
      chk("empty_pp_cnt", underrun_cnt, 1);
      tick();
      chk("empty_pp_pulse_end", underrun, 0);
      spi_ready = 1'b0;
      tick();
      spi_ready = 1'b1; in_valid = 1'b1; in_data = 12'h888; in_pd = 2'd1;
      tick();
      in_valid = 1'b0;
      chk("ne_pp_data", data, 12'h777);
      chk("ne_pp_level", level, 1);
      chk("ne_pp_underrun", underrun, 0);
      frame();
      chk("drain_data", data, 12'h888);
      chk("drain_pd", pd, 2'd1);
      chk("drain_level", level, 0);

      spi_ready = 1'b0;
      tick();
      spi_ready = 1'b1; clear_cnt = 1'b1;
      tick();
      clear_cnt = 1'b0;
      chk("clr_win_pulse", underrun, 1);
      chk("clr_win_cnt", underrun_cnt, 0);
      chk("clr_win_data", data, 12'h888);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
